pdm_demodulator: RTL
====================

# pdm_demodulator

Recovers a WIDTH-bit level from a 1-bit pulse-density stream, such as the serial output of the sigma-delta modulator. It counts ones over a fixed window of 2^WIDTH samples (a boxcar/decimate-by-2^WIDTH filter) and registers each window's result with a one-cycle valid strobe. Typical uses:
- Loopback checking of the modulator on-chip.
- Reading externally generated PDM signals (e.g. spike-rate inputs) into the neuron datapath.

## Interface
Parameters:
- WIDTH, default 8: output width; window length is 2^WIDTH samples.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- enable  input  1  high = sample pdm_in this cycle; low = hold window and counters in restart state.
- pdm_in  input  1  PDM bit stream, one sample per enabled cycle.
- value  output  WIDTH  last completed window's ones count, saturated to 2^WIDTH-1.
- valid  output  1  one-cycle pulse when value is updated.
- saturated  output  1  high while value holds a clipped result (window count was 2^WIDTH).

## Operation
- State:
  - window counter wcnt, WIDTH bits.
  - ones counter ocnt, WIDTH+1 bits.
  - output registers value, valid, saturated.
- Reset (reset_n low, asynchronous): wcnt=0, ocnt=0, value=0, valid=0, saturated=0.
- enable high, wcnt != 2^WIDTH-1:
  - ocnt <= ocnt + s.
  - wcnt <= wcnt+1.
  - valid <= 0.
- enable high, wcnt == 2^WIDTH-1 (last sample of window):
  - Window total t = ocnt + s, computed WIDTH+1 bits wide.
  - value <= (t == 2^WIDTH) ? 2^WIDTH-1 : t[WIDTH-1:0].
  - saturated <= (t == 2^WIDTH).
  - valid <= 1.
  - ocnt <= 0; wcnt <= 0 (wrap).
- enable low:
  - wcnt <= 0, ocnt <= 0; partial window discarded.
  - value and saturated hold.
  - valid <= 0.
- s is pdm_in, or its synchronized copy when PDM_DEMOD_SYNC_EN is defined.
- ocnt never exceeds 2^WIDTH; no wrap of ocnt is possible.
- Reset mid-window discards all partial state; first valid after release follows a full 2^WIDTH enabled samples.

## Timing
- Window = exactly 2^WIDTH consecutive enabled cycles.
- valid asserts on the clock edge that consumes the window's last sample, i.e. it is visible the cycle after that sample is presented.
- value/saturated change only on that same edge.
- valid is never high two cycles in a row. Minimum spacing between valid pulses is 2^WIDTH cycles.
- Latency pdm_in to value: 1 cycle after the last window sample, plus 2 cycles with PDM_DEMOD_SYNC_EN.
- enable deassertion for any cycle restarts the window; no valid is generated for the interrupted window.

## Configuration
- PDM_DEMOD_SYNC_EN defined:
  - pdm_in passes through a 2-flop synchronizer (reset to 0) before counting.
  - For async external sources.
  - Adds 2 cycles latency; synchronizer keeps running regardless of enable.
- Undefined: pdm_in is sampled directly (source must be synchronous to clk).

## Structure
- Shared package pdm_pkg:
  - Default WIDTH constant.
  - Function/constant for window length 2^WIDTH.
  - Saturation max 2^WIDTH-1.
  - The modulator and demodulator both import it.
- Sub-module sync_2ff (1-bit, async active-low reset), instantiated only under PDM_DEMOD_SYNC_EN.
- Everything else in the single pdm_demodulator module.

## Test plan
All scenarios use WIDTH=4 (16-sample window) unless stated; enable high throughout unless stated.
- pdm_in=0 constant → valid every 16 cycles, value=0, saturated=0.
- pdm_in=1 constant → value=15, saturated=1 on every valid.
- Alternating 1,0 → value=8, saturated=0.
- Pattern of 5 ones then 11 zeros per window → value=5.
- Interrupts:
  - Drop enable for 1 cycle at sample 10 → no valid for that window; next valid 16 enabled cycles after re-enable, and value unchanged in between.
  - Assert reset_n low mid-window → value, valid, saturated = 0 immediately (asynchronously).
- Loopback with the modulator (WIDTH=8), held in reset together, modulator value=128 → every window after the first reports value=128; modulator value=255 → steady-state 255. With PDM_DEMOD_SYNC_EN defined, the same values appear and valid shifts by 2 cycles.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared PDM constants and helpers for the sigma-delta modulator and the demodulator.
package pdm_pkg;

  localparam int PDM_DEFAULT_WIDTH = 8;

  function automatic int window_len(input int w);
    return 1 << w;
  endfunction

  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pdm_demodulator_sync_2ff.sv
// Two-flop synchronizer for an asynchronous PDM source; built only when PDM_DEMOD_SYNC_EN is defined.
`ifdef PDM_DEMOD_SYNC_EN
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/pdm_demodulator.sv
// Boxcar PDM demodulator: counts ones over 2^WIDTH enabled samples and strobes the saturated total.
// Optional input synchronizer selected by the PDM_DEMOD_SYNC_EN macro.
module pdm_demodulator
  import pdm_pkg::*;
#(
  parameter int WIDTH = PDM_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pdm_in,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             saturated
);

  localparam logic [WIDTH:0]   WIN_LEN   = (WIDTH+1)'(window_len(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MAX   = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] WCNT_LAST = SAT_MAX;

  logic             sample;
  logic [WIDTH-1:0] wcnt;
  logic [WIDTH:0]   ocnt;
  logic [WIDTH:0]   total;

  function automatic logic [WIDTH-1:0] sat_value(input logic [WIDTH:0] t);
    if (t == WIN_LEN) return SAT_MAX;
    return t[WIDTH-1:0];
  endfunction

`ifdef PDM_DEMOD_SYNC_EN
  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pdm_in),
    .q       (sample)
  );
`else
  assign sample = pdm_in;
`endif

  // ocnt is bounded by the window length, so WIDTH+1 bits never wrap
  assign total = ocnt + {{WIDTH{1'b0}}, sample};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt      <= '0;
      ocnt      <= '0;
      value     <= '0;
      valid     <= 1'b0;
      saturated <= 1'b0;
    end else if (!enable) begin
      wcnt  <= '0;
      ocnt  <= '0;
      valid <= 1'b0;
    end else if (wcnt == WCNT_LAST) begin
      value     <= sat_value(total);
      saturated <= (total == WIN_LEN);
      valid     <= 1'b1;
      wcnt      <= '0;
      ocnt      <= '0;
    end else begin
      ocnt  <= total;
      wcnt  <= wcnt + WIDTH'(1);
      valid <= 1'b0;
    end
  end

endmodule
